muldiv_ctrl: RTL and testbench

Sequencer for the multi-cycle multiply and divide units of the datapath. It accepts MULT/DIV/MTHI/MTLO requests from the main control unit and pulses the selected unit's load input. It counts the unit's fixed latency, then captures the result into the architectural HI/LO registers. It stalls HI/LO readers while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_timer.sv | 30 +++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM states, cycle defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MTHI = 2'b10;
   localparam logic [1:0] OP_MTLO = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RUN     = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam int MULT_CYCLES_DEF = 33;
   localparam int DIV_CYCLES_DEF  = 33;

   // Wide enough for any realistic unit latency.
   localparam int CNT_W = 8;

   // The timer reaches zero on the last RUN cycle, so it starts one below the latency.
   function automatic logic [CNT_W-1:0] cycles_to_cnt(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Loadable down-counter with a zero flag, timing the active unit's latency.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; counts while enabled and parks at zero.
module muldiv_timer
   import muldiv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Load has priority over counting; never wrap below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV through the multi-cycle units into HI/LO; MTHI/MTLO write directly (optional DIV_ZERO_EXC_EN).
// Latency: HI/LO written CYCLES+2 edges after acceptance, done the cycle after; MTHI/MTLO next edge.
// Backpressure: op_ready only in IDLE, requests outside it are dropped; stall = rd_req & busy.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        op_ready,
   output logic        mult_load,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic        div_load,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   input  logic        rd_req,
   output logic        stall
`ifdef DIV_ZERO_EXC_EN
   ,
   output logic        div_zero
`endif
);

   localparam logic [CNT_W-1:0] MULT_LOAD_VAL = cycles_to_cnt(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD_VAL  = cycles_to_cnt(DIV_CYCLES);

   state_t      state, state_nxt;
   logic        sel_div;
   logic [31:0] opnd_a, opnd_b;
   logic [31:0] hi_q, lo_q;
   logic        done_q;
   logic        tmr_zero;
   logic        accept, start_req, launch;

   assign accept    = op_valid && (state == ST_IDLE);
   assign start_req = accept && ((op_code == OP_MULT) || (op_code == OP_DIV));

`ifdef DIV_ZERO_EXC_EN
   logic dz_hit;
   assign dz_hit = accept && (op_code == OP_DIV) && (op_b == '0);
   assign launch = start_req && !dz_hit;

   // One-cycle flag for a divide-by-zero request that was swallowed in IDLE.
   always_ff @(posedge clk) begin
      if (reset) div_zero <= 1'b0;
      else       div_zero <= dz_hit;
   end
`else
   assign launch = start_req;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state plus per-state handshake and load outputs.
   always_comb begin
      state_nxt = state;
      op_ready  = 1'b0;
      busy      = 1'b0;
      mult_load = 1'b0;
      div_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (launch) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            busy      = 1'b1;
            mult_load = !sel_div;
            div_load  = sel_div;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (tmr_zero) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            busy      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   muldiv_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (state == ST_LOAD),
      .load_val (sel_div ? DIV_LOAD_VAL : MULT_LOAD_VAL),
      .en       (state == ST_RUN),
      .zero     (tmr_zero)
   );

   // Operand/unit capture on launch, HI/LO writes from the unit or MTHI/MTLO, done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         opnd_a  <= '0;
         opnd_b  <= '0;
         sel_div <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state == ST_CAPTURE);
         if (launch) begin
            opnd_a  <= op_a;
            opnd_b  <= op_b;
            sel_div <= (op_code == OP_DIV);
         end
         if (state == ST_CAPTURE) begin
            hi_q <= sel_div ? div_hi : mult_hi;
            lo_q <= sel_div ? div_lo : mult_lo;
         end else begin
            if (accept && (op_code == OP_MTHI)) hi_q <= op_a;
            if (accept && (op_code == OP_MTLO)) lo_q <= op_a;
         end
      end
   end

   // Both units see the same operand pair; only the loaded one acts on it.
   assign mult_a = opnd_a;
   assign mult_b = opnd_b;
   assign div_a  = opnd_a;
   assign div_b  = opnd_b;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign done   = done_q;
   assign stall  = rd_req & busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl with behavioural multiply/divide units and a result/timing reference model.
// Latency: checks HI/LO, busy, stall and done timing per operation.
// Backpressure: drives ignored requests while busy to confirm they are dropped.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MCYC = 33;
   localparam int DCYC = 17;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code = 2'b00;
   logic [31:0] op_a = '0, op_b = '0;
   logic        rd_req = 1'b0;
   logic        op_ready, mult_load, div_load, busy, done, stall;
   logic [31:0] mult_a, mult_b, mult_hi, mult_lo;
   logic [31:0] div_a, div_b, div_hi, div_lo, hi, lo;
`ifdef DIV_ZERO_EXC_EN
   logic        div_zero;
`endif

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.MULT_CYCLES(MCYC), .DIV_CYCLES(DCYC)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .mult_load(mult_load), .mult_a(mult_a), .mult_b(mult_b),
      .mult_hi(mult_hi), .mult_lo(mult_lo),
      .div_load(div_load), .div_a(div_a), .div_b(div_b),
      .div_hi(div_hi), .div_lo(div_lo),
      .hi(hi), .lo(lo), .busy(busy), .done(done),
      .rd_req(rd_req), .stall(stall)
`ifdef DIV_ZERO_EXC_EN
      , .div_zero(div_zero)
`endif
   );

   // Behavioural units: result is garbage until CYCLES edges after the load edge.
   logic [63:0] m_res = '0, d_res = '0;
   int m_cnt = 0, d_cnt = 0;
   always @(posedge clk) begin
      if (mult_load) begin
         m_res <= {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
         m_cnt <= MCYC;
      end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      if (div_load) begin
         d_res <= (div_b == 0) ? {div_a, 32'hFFFF_FFFF} : {div_a % div_b, div_a / div_b};
         d_cnt <= DCYC;
      end else if (d_cnt > 0) d_cnt <= d_cnt - 1;
   end
   assign mult_hi = (m_cnt == 0) ? m_res[63:32] : 32'hBAD0_BAD0;
   assign mult_lo = (m_cnt == 0) ? m_res[31:0]  : 32'hBAD1_BAD1;
   assign div_hi  = (d_cnt == 0) ? d_res[63:32] : 32'hBAD2_BAD2;
   assign div_lo  = (d_cnt == 0) ? d_res[31:0]  : 32'hBAD3_BAD3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result {hi, lo}: signed 64-bit product, or {remainder, quotient}.
   function automatic logic [63:0] ref_result(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (code == OP_MULT) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   // Issue one op at the current negedge; returns at the negedge of its done cycle (or next cycle).
   task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                         input bit rd, input bit junk);
      logic [63:0] r;
      int cyc, n_busy, n_stall, n_mload, n_dload, n_done, n_hold, n_opnd;
      chk("op_ready_in", 32'(op_ready), 1);
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b; rd_req = rd;
      @(negedge clk);
      op_valid = 1'b0;
      if (code == OP_MTHI || code == OP_MTLO) begin
         if (code == OP_MTHI) exp_hi = a; else exp_lo = a;
         chk("mt_hi", hi, exp_hi);
         chk("mt_lo", lo, exp_lo);
         chk("mt_busy", 32'(busy), 0);
         chk("mt_done", 32'(done), 0);
         return;
      end
`ifdef DIV_ZERO_EXC_EN
      if (code == OP_DIV && b == 0) begin
         chk("dz_pulse", 32'(div_zero), 1);
         chk("dz_busy", 32'(busy), 0);
         chk("dz_hi", hi, exp_hi);
         chk("dz_lo", lo, exp_lo);
         @(negedge clk);
         chk("dz_single", 32'(div_zero), 0);
         chk("dz_busy2", 32'(busy), 0);
         chk("dz_done", 32'(done), 0);
         return;
      end
`endif
      cyc = (code == OP_MULT) ? MCYC : DCYC;
      r = ref_result(code, a, b);
      n_busy = 0; n_stall = 0; n_mload = 0; n_dload = 0; n_done = 0; n_hold = 0; n_opnd = 0;
      while (busy && n_busy < 200) begin
         n_busy++;
         if (n_busy == 1) chk("load_first", 32'((code == OP_MULT) ? mult_load : div_load), 1);
         if (stall) n_stall++;
         if (mult_load) n_mload++;
         if (div_load) n_dload++;
         if (done) n_done++;
         if (hi !== exp_hi || lo !== exp_lo) n_hold++;
         if ((code == OP_MULT) ? (mult_a !== a || mult_b !== b) : (div_a !== a || div_b !== b)) n_opnd++;
         if (junk) begin
            op_valid = 1'($urandom_range(0, 1)); op_code = OP_MTHI; op_a = $urandom;
         end
         @(negedge clk);
      end
      op_valid = 1'b0;
      chk("busy_len", n_busy, cyc + 2);
      chk("stall_len", n_stall, rd ? cyc + 2 : 0);
      chk("mult_loads", n_mload, (code == OP_MULT) ? 1 : 0);
      chk("div_loads", n_dload, (code == OP_DIV) ? 1 : 0);
      chk("done_early", n_done, 0);
      chk("hilo_hold", n_hold, 0);
      chk("opnd_stable", n_opnd, 0);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      chk("done_pulse", 32'(done), 1);
      chk("stall_done", 32'(stall), 0);
      chk("res_hi", hi, exp_hi);
      chk("res_lo", lo, exp_lo);
      chk("ready_done", 32'(op_ready), 1);
   endtask

   initial begin
      int n_done, n_busy, gap;
      logic [1:0]  c;
      logic [31:0] a, b;
      rd_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(op_ready), 1);
      chk("rst_mload", 32'(mult_load), 0);
      chk("rst_dload", 32'(div_load), 0);
      chk("rst_opnd", mult_a | mult_b | div_a | div_b, 0);
      chk("rst_stall", 32'(stall), 0);
`ifdef DIV_ZERO_EXC_EN
      chk("rst_dz", 32'(div_zero), 0);
`endif
      reset = 1'b0; rd_req = 1'b0;
      @(negedge clk);

      // Directed cases.
      run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
      chk("mul_dir_hi", hi, 32'hFFFF_FFFF);
      chk("mul_dir_lo", lo, 32'hFFFF_FFEB);
      run_op(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
      chk("div_dir_hi", hi, 32'd2);
      chk("div_dir_lo", lo, 32'd14);
      run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
      run_op(OP_MTLO, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
      chk("mt_dir_hi", hi, 32'hDEAD_BEEF);
      chk("mt_dir_lo", lo, 32'h1234_5678);
      run_op(OP_DIV, 32'd55, 32'd0, 1'b1, 1'b0);
      @(negedge clk);

      // Reset while RUN has the counter at 10 (24 cycles after acceptance).
      op_valid = 1'b1; op_code = OP_MULT; op_a = 32'd3; op_b = 32'd5;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (23) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_hi = '0; exp_lo = '0;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ready", 32'(op_ready), 1);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      chk("mid_rst_load", 32'(mult_load | div_load), 0);
      n_done = 0; n_busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      chk("mid_rst_nodone", n_done, 0);
      chk("mid_rst_nobusy", n_busy, 0);

      // Randomized ops, back-to-back or with short gaps.
      repeat (40) begin
         c = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 300));
            default: b = $urandom;
         endcase
         run_op(c, a, b, 1'($urandom_range(0, 1)), 1'b1);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

endmodule
